// File: rtl/spwm_ref_sched_if.sv
// rtl/spwm_ref_sched_if.sv - shared multiplier operand/product bus
//
// Purpose: carries the two registered operands out to the shared Q4.28
// multiplier and its combinational product back.
// Signals:
//   mul_a  W  operand A (driven by the scheduler)
//   mul_b  W  operand B (driven by the scheduler)
//   mul_p  W  product of mul_a x mul_b (driven by the multiplier)
// Modports: master = scheduler side, slave = multiplier side.

interface spwm_ref_sched_if #(
    parameter int W = 32
);
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_p;

    modport master (output mul_a, output mul_b, input mul_p);
    modport slave  (input mul_a, input mul_b, output mul_p);
endinterface

// File: rtl/spwm_ref_sched.sv
// rtl/spwm_ref_sched.sv - three-phase SPWM reference scheduler
//
// Purpose: time-shares one Q4.28 multiplier across x/y/z, scales each by a
// slew-limited modulation index and commits the scaled set atomically.
// Ports:
//   clk, res          clock, asynchronous active-high reset
//   en, valley        modulator enable (level), carrier-valley pulse
//   x, y, z           signed phase references (Q4.28)
//   m_target, m_load  requested modulation index and its load strobe
//   mul               shared multiplier bus (master side)
//   xm, ym, zm        committed scaled references
//   ref_valid         one-cycle commit pulse
//   gate_en           bridge switch-enable qualifier
//   busy, overrun     sequence in progress, sticky valley-while-busy flag
//   m_active          modulation index currently in use

module spwm_ref_sched #(
    parameter int           W      = 32,
    parameter logic [W-1:0] M_INIT = 32'h0000_0000,
    parameter logic [W-1:0] M_MAX  = 32'h1000_0000,
    parameter logic [W-1:0] M_STEP = 32'h0010_0000
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 en,
    input  logic                 valley,
    input  logic [W-1:0]         x,
    input  logic [W-1:0]         y,
    input  logic [W-1:0]         z,
    input  logic [W-1:0]         m_target,
    input  logic                 m_load,
    spwm_ref_sched_if.master     mul,
    output logic [W-1:0]         xm,
    output logic [W-1:0]         ym,
    output logic [W-1:0]         zm,
    output logic                 ref_valid,
    output logic                 gate_en,
    output logic                 busy,
    output logic                 overrun,
    output logic [W-1:0]         m_active
);
    typedef enum logic [2:0] {IDLE, MA, MB, MC, COMMIT} state_t;

    localparam logic signed [W-1:0] STEP_S = M_STEP;

    state_t              state;
    state_t              state_nx;
    logic [W-1:0]        target;
    logic [W-1:0]        y_sh;
    logic [W-1:0]        z_sh;
    logic [W-1:0]        p_x;
    logic [W-1:0]        p_y;
    logic [W-1:0]        p_z;
    logic [W-1:0]        m_next;
    logic signed [W-1:0] diff;
    logic                en_d;

    assign busy = (state != IDLE);

    // Both operands live in [0, M_MAX], so the difference cannot overflow.
    assign diff = $signed(target) - $signed(m_active);

    always_comb begin
        m_next = target;
        if (diff > STEP_S) begin
            m_next = m_active + M_STEP;
        end else if (diff < -STEP_S) begin
            m_next = m_active - M_STEP;
        end
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (valley) state_nx = MA;
                MA:      state_nx = MB;
                MB:      state_nx = MC;
                MC:      state_nx = COMMIT;
                COMMIT:  state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Target is written from any state; an accepted valley in the same
    // cycle still steps toward the old value since it reads target here.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            target <= M_INIT;
        end else if (m_load) begin
            if (m_target[W-1]) begin
                target <= '0;
            end else if (m_target > M_MAX) begin
                target <= M_MAX;
            end else begin
                target <= m_target;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            xm        <= '0;
            ym        <= '0;
            zm        <= '0;
            p_x       <= '0;
            p_y       <= '0;
            p_z       <= '0;
            y_sh      <= '0;
            z_sh      <= '0;
            mul.mul_a <= '0;
            mul.mul_b <= '0;
            ref_valid <= 1'b0;
            gate_en   <= 1'b0;
            overrun   <= 1'b0;
            en_d      <= 1'b0;
            m_active  <= M_INIT;
        end else begin
            ref_valid <= 1'b0;
            en_d      <= en;
            if (en && !en_d) begin
                overrun <= 1'b0;
            end else if (valley && busy) begin
                overrun <= 1'b1;
            end
            if (!en) begin
                // Drop the sequence; committed references stay untouched.
                gate_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (valley) begin
                            // x goes straight to the multiplier; only y/z
                            // need holding for the later slots.
                            y_sh      <= y;
                            z_sh      <= z;
                            m_active  <= m_next;
                            mul.mul_a <= x;
                            mul.mul_b <= m_next;
                        end
                    end
                    MA: begin
                        p_x       <= mul.mul_p;
                        mul.mul_a <= y_sh;
                        mul.mul_b <= m_active;
                    end
                    MB: begin
                        p_y       <= mul.mul_p;
                        mul.mul_a <= z_sh;
                    end
                    MC: begin
                        p_z <= mul.mul_p;
                    end
                    COMMIT: begin
                        xm        <= p_x;
                        ym        <= p_y;
                        zm        <= p_z;
                        ref_valid <= 1'b1;
                        gate_en   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spwm_ref_sched.sv
// tb/tb_spwm_ref_sched.sv - testbench for spwm_ref_sched

module tb_spwm_ref_sched;
    localparam logic [31:0] M_INIT = 32'h0000_0000;
    localparam logic [31:0] M_MAX  = 32'h1000_0000;
    localparam logic [31:0] M_STEP = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        res;
    logic        en;
    logic        valley;
    logic        m_load;
    logic [31:0] x, y, z, m_target;
    logic [31:0] xm, ym, zm, m_active;
    logic        ref_valid, gate_en, busy, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = 64'($signed(a)) * 64'($signed(b));
        return p[59:28];
    endfunction

    function automatic logic [31:0] clampf(input logic [31:0] t);
        if ($signed(t) < 0) return 32'h0;
        if (t > M_MAX) return M_MAX;
        return t;
    endfunction

    function automatic logic [31:0] slew(input logic [31:0] cur, input logic [31:0] tgt);
        longint d;
        d = longint'($signed(tgt)) - longint'($signed(cur));
        if (d > longint'(M_STEP)) return cur + M_STEP;
        if (d < -longint'(M_STEP)) return cur - M_STEP;
        return tgt;
    endfunction

    spwm_ref_sched_if #(.W(32)) mul_bus();
    assign mul_bus.mul_p = qmul(mul_bus.mul_a, mul_bus.mul_b);

    spwm_ref_sched #(
        .W(32), .M_INIT(M_INIT), .M_MAX(M_MAX), .M_STEP(M_STEP)
    ) dut (
        .clk(clk), .res(res), .en(en), .valley(valley),
        .x(x), .y(y), .z(z), .m_target(m_target), .m_load(m_load),
        .mul(mul_bus),
        .xm(xm), .ym(ym), .zm(zm), .ref_valid(ref_valid), .gate_en(gate_en),
        .busy(busy), .overrun(overrun), .m_active(m_active)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        valley = 1'b0;
        m_load = 1'b0;
        res = 1'b1;
        #2;
        res = 1'b0;
    endtask

    task automatic load_target(input logic [31:0] t);
        m_target = t;
        m_load = 1'b1;
        tick();
        m_load = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (xm !== 32'h0) begin n_fail++; $display("FAIL reset_xm: got %h want 0", xm); end
        n_checks++; if (ym !== 32'h0) begin n_fail++; $display("FAIL reset_ym: got %h want 0", ym); end
        n_checks++; if (zm !== 32'h0) begin n_fail++; $display("FAIL reset_zm: got %h want 0", zm); end
        n_checks++; if (mul_bus.mul_a !== 32'h0 || mul_bus.mul_b !== 32'h0) begin n_fail++; $display("FAIL reset_mul: got %h/%h want 0/0", mul_bus.mul_a, mul_bus.mul_b); end
        n_checks++; if ({ref_valid, gate_en, busy, overrun} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {ref_valid, gate_en, busy, overrun}); end
        n_checks++; if (m_active !== M_INIT) begin n_fail++; $display("FAIL reset_m_active: got %h want %h", m_active, M_INIT); end
        tick();
        res = 1'b0;
        tick();
        n_checks++; if (dut.target !== M_INIT) begin n_fail++; $display("FAIL reset_target: got %h want %h", dut.target, M_INIT); end
        n_checks++; if ({ref_valid, gate_en, busy, overrun} !== 4'b0) begin n_fail++; $display("FAIL idle_flags: got %b want 0000", {ref_valid, gate_en, busy, overrun}); end
    endtask

    task automatic test_clamp();
        load_target(32'h2000_0000);
        n_checks++; if (dut.target !== 32'h1000_0000) begin n_fail++; $display("FAIL clamp_high: got %h want 10000000", dut.target); end
        load_target(32'hF000_0000);
        n_checks++; if (dut.target !== 32'h0) begin n_fail++; $display("FAIL clamp_neg: got %h want 0", dut.target); end
        load_target(32'h0123_4567);
        n_checks++; if (dut.target !== 32'h0123_4567) begin n_fail++; $display("FAIL clamp_pass: got %h want 01234567", dut.target); end
    endtask

    task automatic test_scaling();
        logic [31:0] m_exp;
        apply_reset();
        en = 1'b1;
        load_target(32'h0800_0000);
        m_exp = M_INIT;
        // Ramp to 0.5 with valleys at the minimum 5-clock spacing.
        for (int i = 0; i < 128; i++) begin
            m_exp = slew(m_exp, 32'h0800_0000);
            x = $urandom; y = $urandom; z = $urandom;
            valley = 1'b1; tick(); valley = 1'b0;
            n_checks++; if (m_active !== m_exp) begin n_fail++; $display("FAIL ramp_m_active[%0d]: got %h want %h", i, m_active, m_exp); end
            tick(); tick(); tick();
            n_checks++; if (ref_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_early_valid[%0d]: got %b want 0", i, ref_valid); end
            if (i == 0) begin
                n_checks++; if (gate_en !== 1'b0) begin n_fail++; $display("FAIL gate_before_commit: got %b want 0", gate_en); end
            end
            tick();
            n_checks++; if (ref_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_valid[%0d]: got %b want 1", i, ref_valid); end
            n_checks++; if (xm !== qmul(x, m_exp)) begin n_fail++; $display("FAIL ramp_xm[%0d]: got %h want %h", i, xm, qmul(x, m_exp)); end
            n_checks++; if (gate_en !== 1'b1) begin n_fail++; $display("FAIL ramp_gate[%0d]: got %b want 1", i, gate_en); end
        end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ramp_overrun: got %b want 0", overrun); end
        n_checks++; if (m_active !== 32'h0800_0000) begin n_fail++; $display("FAIL ramp_final_m: got %h want 08000000", m_active); end
        x = 32'h1000_0000; y = 32'hF800_0000; z = 32'h0;
        valley = 1'b1; tick(); valley = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (ref_valid !== 1'b0) begin n_fail++; $display("FAIL scale_early_valid: got %b want 0", ref_valid); end
        tick();
        n_checks++; if (ref_valid !== 1'b1) begin n_fail++; $display("FAIL scale_valid: got %b want 1", ref_valid); end
        n_checks++; if (xm !== 32'h0800_0000) begin n_fail++; $display("FAIL scale_xm: got %h want 08000000", xm); end
        n_checks++; if (ym !== 32'hFC00_0000) begin n_fail++; $display("FAIL scale_ym: got %h want fc000000", ym); end
        n_checks++; if (zm !== 32'h0) begin n_fail++; $display("FAIL scale_zm: got %h want 0", zm); end
        tick();
        n_checks++; if (ref_valid !== 1'b0) begin n_fail++; $display("FAIL scale_valid_width: got %b want 0", ref_valid); end
    endtask

    task automatic test_slew();
        logic [31:0] exp_m [4];
        exp_m[0] = 32'h0010_0000; exp_m[1] = 32'h0020_0000;
        exp_m[2] = 32'h0030_0000; exp_m[3] = 32'h0030_0000;
        apply_reset();
        en = 1'b1;
        load_target(32'h0030_0000);
        for (int i = 0; i < 4; i++) begin
            valley = 1'b1; tick(); valley = 1'b0;
            n_checks++; if (m_active !== exp_m[i]) begin n_fail++; $display("FAIL slew[%0d]: got %h want %h", i, m_active, exp_m[i]); end
            for (int k = 0; k < 9; k++) tick();
        end
    endtask

    task automatic test_overrun();
        logic [31:0] tgt, x1, y1, z1, m1, xa, ya, za, ma, xb, yb, zb, mb;
        apply_reset();
        en = 1'b1;
        tgt = 32'h0400_0000;
        load_target(tgt);
        m1 = slew(M_INIT, tgt);
        x1 = $urandom; y1 = $urandom; z1 = $urandom;
        x = x1; y = y1; z = z1;
        valley = 1'b1; tick(); valley = 1'b0;
        tick();
        x = $urandom; y = $urandom; z = $urandom;
        valley = 1'b1; tick(); valley = 1'b0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
        tick(); tick();
        n_checks++; if (ref_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b want 1", ref_valid); end
        n_checks++; if (xm !== qmul(x1, m1) || ym !== qmul(y1, m1) || zm !== qmul(z1, m1)) begin n_fail++; $display("FAIL overrun_capture: got %h %h %h want %h %h %h", xm, ym, zm, qmul(x1, m1), qmul(y1, m1), qmul(z1, m1)); end
        n_checks++; if (m_active !== m1) begin n_fail++; $display("FAIL overrun_no_step: got %h want %h", m_active, m1); end
        en = 1'b0; tick(); en = 1'b1; tick();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", overrun); end
        n_checks++; if (gate_en !== 1'b0) begin n_fail++; $display("FAIL gate_after_reenable: got %b want 0", gate_en); end
        // Valley landing on the COMMIT cycle is an overrun; one cycle later is accepted.
        ma = slew(m1, tgt);
        xa = $urandom; ya = $urandom; za = $urandom;
        x = xa; y = ya; z = za;
        valley = 1'b1; tick(); valley = 1'b0;
        tick(); tick(); tick();
        mb = slew(ma, tgt);
        xb = $urandom; yb = $urandom; zb = $urandom;
        x = xb; y = yb; z = zb;
        valley = 1'b1; tick();
        n_checks++; if (ref_valid !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL commit_cycle_valley: got valid=%b ovr=%b want 1/1", ref_valid, overrun); end
        n_checks++; if (xm !== qmul(xa, ma) || m_active !== ma) begin n_fail++; $display("FAIL commit_cycle_data: got %h m=%h want %h m=%h", xm, m_active, qmul(xa, ma), ma); end
        tick(); valley = 1'b0;
        n_checks++; if (busy !== 1'b1 || m_active !== mb) begin n_fail++; $display("FAIL first_idle_accept: got busy=%b m=%h want 1 m=%h", busy, m_active, mb); end
        tick(); tick(); tick(); tick();
        n_checks++; if (ref_valid !== 1'b1 || xm !== qmul(xb, mb) || ym !== qmul(yb, mb) || zm !== qmul(zb, mb)) begin n_fail++; $display("FAIL first_idle_commit: got v=%b %h %h %h want 1 %h %h %h", ref_valid, xm, ym, zm, qmul(xb, mb), qmul(yb, mb), qmul(zb, mb)); end
        n_checks++; if (gate_en !== 1'b1) begin n_fail++; $display("FAIL gate_after_commit: got %b want 1", gate_en); end
    endtask

    task automatic test_en_drop();
        logic [31:0] px, py, pz;
        tick();
        px = xm; py = ym; pz = zm;
        x = $urandom; y = $urandom; z = $urandom;
        valley = 1'b1; tick(); valley = 1'b0;
        tick();
        en = 1'b0;
        tick();
        n_checks++; if (gate_en !== 1'b0 || busy !== 1'b0 || ref_valid !== 1'b0) begin n_fail++; $display("FAIL en_drop_flags: got gate=%b busy=%b valid=%b want 0/0/0", gate_en, busy, ref_valid); end
        n_checks++; if (xm !== px || ym !== py || zm !== pz) begin n_fail++; $display("FAIL en_drop_hold: got %h %h %h want %h %h %h", xm, ym, zm, px, py, pz); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (ref_valid !== 1'b0 || xm !== px) begin n_fail++; $display("FAIL en_drop_no_commit[%0d]: got valid=%b xm=%h want 0 xm=%h", k, ref_valid, xm, px); end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        tick();
        x = 32'h0800_0000; y = 32'h0800_0000; z = 32'h0800_0000;
        valley = 1'b1; tick(); valley = 1'b0;
        tick(); tick(); tick(); tick();
        valley = 1'b1; tick(); valley = 1'b0;
        tick(); tick();
        #2 res = 1'b1;
        #1;
        n_checks++; if (xm !== 32'h0 || ym !== 32'h0 || zm !== 32'h0) begin n_fail++; $display("FAIL async_refs: got %h %h %h want 0 0 0", xm, ym, zm); end
        n_checks++; if ({ref_valid, gate_en, busy, overrun} !== 4'b0) begin n_fail++; $display("FAIL async_flags: got %b want 0000", {ref_valid, gate_en, busy, overrun}); end
        n_checks++; if (m_active !== M_INIT || mul_bus.mul_a !== 32'h0 || mul_bus.mul_b !== 32'h0) begin n_fail++; $display("FAIL async_m: got m=%h a=%h b=%h want %h 0 0", m_active, mul_bus.mul_a, mul_bus.mul_b, M_INIT); end
        #1 res = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] e_tgt, e_m, e_xm, e_ym, e_zm, px, py, pz;
        logic        e_rv, e_gate, e_ov;
        int          age;
        apply_reset();
        en = 1'b1;
        e_tgt = M_INIT; e_m = M_INIT; e_xm = 0; e_ym = 0; e_zm = 0;
        px = 0; py = 0; pz = 0;
        e_rv = 0; e_gate = 0; e_ov = 0; age = -1;
        for (int c = 0; c < 600; c++) begin
            tick();
            n_checks++; if (ref_valid !== e_rv || gate_en !== e_gate || overrun !== e_ov || busy !== (age >= 0)) begin n_fail++; $display("FAIL rand_flags[%0d]: got v=%b g=%b o=%b b=%b want %b %b %b %b", c, ref_valid, gate_en, overrun, busy, e_rv, e_gate, e_ov, age >= 0); end
            n_checks++; if (xm !== e_xm || ym !== e_ym || zm !== e_zm || m_active !== e_m) begin n_fail++; $display("FAIL rand_data[%0d]: got %h %h %h m=%h want %h %h %h m=%h", c, xm, ym, zm, m_active, e_xm, e_ym, e_zm, e_m); end
            valley = ($urandom_range(0, 3) == 0);
            m_load = ($urandom_range(0, 7) == 0);
            m_target = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h1000_0000);
            x = $urandom; y = $urandom; z = $urandom;
            e_rv = 1'b0;
            if (age >= 0) begin
                if (valley) e_ov = 1'b1;
                if (age == 3) begin
                    e_xm = px; e_ym = py; e_zm = pz;
                    e_rv = 1'b1; e_gate = 1'b1; age = -1;
                end else begin
                    age++;
                end
            end else if (valley) begin
                e_m = slew(e_m, e_tgt);
                px = qmul(x, e_m); py = qmul(y, e_m); pz = qmul(z, e_m);
                age = 0;
            end
            if (m_load) e_tgt = clampf(m_target);
        end
        valley = 1'b0;
        m_load = 1'b0;
    endtask

    initial begin
        res = 1'b1; en = 1'b0; valley = 1'b0; m_load = 1'b0;
        x = 0; y = 0; z = 0; m_target = 0;
        test_reset();
        test_clamp();
        test_scaling();
        test_slew();
        test_overrun();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spwm_ref_sched.md
# spwm_ref_sched

Reference scheduler for the three-phase SPWM modulator. It time-shares one external Q4.28 fixed-point multiplier (a `qmult` instance, Q=28, N=32) across the three phase references x, y and z. It scales each reference by a slew-limited modulation index. It commits all three scaled references atomically at each carrier valley, so the comparators never see a mixed old/new set. It also gates the bridge switches until the first valid reference set exists.

## Interface
Parameters:
- `W`, 32, data width (signed Q4.28).
- `M_INIT`, 32'h0000_0000, modulation index at reset.
- `M_MAX`, 32'h1000_0000, upper clamp for the requested index (1.0).
- `M_STEP`, 32'h0010_0000, maximum index change per accepted valley (2^-8).

Ports:
- `clk`  in  1  system clock.
- `res`  in  1  reset, asynchronous, active-high.
- `en`  in  1  modulator enable, level.
- `valley`  in  1  one-cycle pulse from the carrier counter at its minimum.
- `x`, `y`, `z`  in  W  signed phase references.
- `m_target`  in  W  requested modulation index.
- `m_load`  in  1  strobe that latches `m_target`.
- `mul_a`, `mul_b`  out  W  operands to the shared multiplier (registered).
- `mul_p`  in  W  combinational multiplier product of `mul_a`×`mul_b`.
- `xm`, `ym`, `zm`  out  W  committed scaled references to the comparators.
- `ref_valid`  out  1  one-cycle pulse on commit.
- `gate_en`  out  1  switch-enable qualifier for the bridge drivers.
- `busy`  out  1  scaling sequence in progress.
- `overrun`  out  1  sticky: a valley arrived while `busy`.
- `m_active`  out  W  index currently in use.

## Operation
- Reset values:
  - `xm`, `ym`, `zm`, `mul_a`, `mul_b`: 0.
  - `ref_valid`, `gate_en`, `busy`, `overrun`: 0.
  - `m_active`: `M_INIT`.
  - Target register: `M_INIT`. State: IDLE.
- `m_load` high: target register ← clamp(`m_target`, 0, `M_MAX`). Negative values load 0. The load may occur in any state.
- FSM states: IDLE, MA, MB, MC, COMMIT.
- IDLE:
  - Condition to start: `valley` with `en`=1.
  - On start, capture `x`, `y`, `z` into shadow registers.
  - On start, step `m_active` toward the target:
    - If |target − m_active| ≤ `M_STEP`, set `m_active` = target.
    - Otherwise add or subtract `M_STEP`.
  - On start, load `mul_a`=x_shadow source (x), `mul_b`=new `m_active`, then go to MA.
- MA:
  - Register `mul_p` into p_x.
  - Drive `mul_a`=y_shadow, `mul_b`=`m_active`.
  - Next state: MB.
- MB:
  - Register `mul_p` into p_y.
  - Drive `mul_a`=z_shadow.
  - Next state: MC.
- MC:
  - Register `mul_p` into p_z.
  - Next state: COMMIT.
- COMMIT:
  - `xm`, `ym`, `zm` ← p_x, p_y, p_z in the same edge.
  - Pulse `ref_valid`, set `gate_en`=1, return to IDLE.
- `busy`=1 in MA, MB, MC and COMMIT.
- Valley while `busy`:
  - The valley is ignored; no recapture and no index step.
  - `overrun` is set.
- `overrun` clears only on `res` or on a rising edge of `en`.
- `en` falling, in any state:
  - At the next edge, `gate_en`=0 and the FSM returns to IDLE.
  - `xm`, `ym`, `zm` hold their values; no `ref_valid` is issued.
  - Partial products are discarded.
- `en` rising: `gate_en` stays 0 until the first COMMIT after it.
- Products are used as returned: Q4.28, truncated by the multiplier. The block does no further rounding and no saturation.
- Index stepping is signed 32-bit arithmetic. No overflow is possible, since the index is bounded to [0, `M_MAX`].

## Timing
- Valley sampled at edge 0. The edges then proceed as follows:
  - Edge 0: multiply x.
  - Edge 1: latch p_x, multiply y.
  - Edge 2: latch p_y, multiply z.
  - Edge 3: latch p_z.
  - Edge 4: outputs update and `ref_valid`=1 for exactly that cycle.
- Commit latency is 4 clocks after the valley edge.
- Minimum valley spacing without overrun is 5 clocks.
- A valley in the same cycle as COMMIT counts as an overrun.
- A valley in the first IDLE cycle after COMMIT is accepted.
- `m_load` coincident with an accepted valley: the step uses the old target; the new target is used from the next valley.
- `res` asserted mid-sequence: all outputs take their reset values immediately (asynchronous).

## Test plan
- Scaling and latency:
  - Stimulus: `M_STEP`=32'h1000_0000; `m_load` with `m_target`=32'h0800_0000 (0.5); then `en`=1 and `valley` with x=32'h1000_0000, y=32'hF800_0000, z=0.
  - Required: 4 clocks later `xm`=32'h0800_0000, `ym`=32'hFC00_0000, `zm`=0; `ref_valid` pulses once; `gate_en` rises.
- Slew limit:
  - Stimulus: defaults; target 32'h0030_0000; four valleys spaced 10 clocks apart.
  - Required: `m_active` steps 0x0010_0000, 0x0020_0000, 0x0030_0000, then stays at 0x0030_0000.
- Clamp:
  - Stimulus: `m_target`=32'h2000_0000, then 32'hF000_0000.
  - Required: the target register holds 32'h1000_0000, then 0.
- Overrun:
  - Stimulus: valleys 2 clocks apart.
  - Required: the second valley is ignored and `overrun`=1; the committed values come from the first capture; `en` toggled low then high clears `overrun`.
- Enable drop mid-sequence:
  - Stimulus: `en`=0 during MB.
  - Required: the next cycle shows `gate_en`=0, `busy`=0, no `ref_valid`, and `xm`/`ym`/`zm` unchanged.
- Asynchronous reset:
  - Stimulus: pulse `res` between clock edges during MC.
  - Required: all outputs are at their reset values before the next edge; `m_active`=`M_INIT`.
